// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kyber_pkg
//  Description : Shared Kyber constants (modulus, polynomial geometry,
//                Barrett reduction constants) and the accumulator state
//                encoding used by polyvec_basemul_acc.
//  Revision    : 1.0  initial release
// ============================================================================
package kyber_pkg;

    localparam int KYBER_Q          = 3329;
    localparam int KYBER_N          = 256;
    localparam int KYBER_K          = 3;
    localparam int KYBER_POLY_WIDTH = 16;

    // round(2^26 / Q); paired with a 26-bit shift this gives a quotient
    // estimate that is exact to within one for |a| well beyond K*(Q-1).
    localparam int BARRETT_V     = 20159;
    localparam int BARRETT_SHIFT = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LAST  = 2'd2
    } acc_state_e;

endpackage : kyber_pkg
`default_nettype wire

// File: rtl/barrett_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : barrett_reduce
//  Description : Combinational signed Barrett reduction of one coefficient.
//                  t = (V*a + 2^(SHIFT-1)) >>> SHIFT   (32-bit product)
//                  r = a - t*Q
//                Output lies in [-(Q-1)/2, (Q-1)/2] for |a| <= K*(Q-1).
//  Ports       : a  - signed W-bit input coefficient
//                r  - signed W-bit reduced coefficient
//  Revision    : 1.0  initial release
// ============================================================================
module barrett_reduce
    import kyber_pkg::*;
#(
    parameter int W = KYBER_POLY_WIDTH
) (
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] r
);

    localparam logic signed [31:0] c_V     = 32'(BARRETT_V);
    localparam logic signed [31:0] c_Q     = 32'(KYBER_Q);
    localparam logic signed [31:0] c_ROUND = 32'sd1 <<< (BARRETT_SHIFT - 1);

    logic signed [31:0] w_a;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_t;

    assign w_a    = {{(32 - W){a[W-1]}}, a};
    assign w_prod = w_a * c_V + c_ROUND;
    // Arithmetic shift floors toward -inf, giving round-to-nearest overall.
    assign w_t    = w_prod >>> BARRETT_SHIFT;
    // The true difference always fits in W bits, so truncation is exact.
    assign r      = W'(w_a - w_t * c_Q);

endmodule : barrett_reduce
`default_nettype wire

// File: rtl/polyvec_basemul_acc.sv
`default_nettype none
// ============================================================================
//  Module      : polyvec_basemul_acc
//  Description : Coefficient-wise accumulation of K streamed basemul result
//                polynomials followed by Barrett reduction of the final sum.
//                Words carry two signed W-bit coefficients, lower half first.
//                Polys 0..K-2 are accumulated into a BEATS-deep buffer; while
//                poly K-1 streams in, each word is summed, reduced and
//                presented on a single registered output stage.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - begin an accumulation (ignored if busy)
//                in_valid/in_ready   - input word handshake, in_data payload
//                out_valid/out_ready - output word handshake
//                out_data            - reduced word {r[2i+1], r[2i]}
//                out_idx, out_last   - word index, high with the final word
//                busy                - high outside IDLE
//                done                - pulse after the final output handshake
//  Revision    : 1.0  initial release
// ============================================================================
module polyvec_basemul_acc
    import kyber_pkg::*;
#(
    parameter int K = KYBER_K,
    parameter int N = KYBER_N,
    parameter int W = KYBER_POLY_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*W-1:0]           in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           out_data,
    output logic [$clog2(N/2)-1:0]   out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int c_BEATS = N / 2;
    localparam int c_BW    = $clog2(c_BEATS);
    localparam int c_PW    = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_ACCUM = ACCUM;
    localparam logic [1:0] c_ST_LAST  = LAST;

    localparam logic [c_BW-1:0] c_BEAT_END     = c_BW'(c_BEATS - 1);
    localparam logic [c_PW-1:0] c_POLY_ACC_END = c_PW'((K > 1) ? K - 2 : 0);

    logic [1:0]       r_state;
    logic [c_BW-1:0]  r_beat;
    logic [c_PW-1:0]  r_poly;
    logic             r_in_done;   // final LAST-phase beat already taken
    logic [2*W-1:0]   r_buf [c_BEATS];

    logic             r_out_valid;
    logic [2*W-1:0]   r_out_data;
    logic [c_BW-1:0]  r_out_idx;
    logic             r_out_last;
    logic             r_done;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_hs;
    logic             w_beat_last;
    logic             w_first_poly;
    logic [2*W-1:0]   w_buf_rd;
    logic [2*W-1:0]   w_sum;
    logic [2*W-1:0]   w_red;

    assign w_buf_rd     = r_buf[r_beat];
    assign w_first_poly = (r_poly == '0);
    assign w_beat_last  = (r_beat == c_BEAT_END);
    assign w_accept     = in_valid && w_in_ready;
    assign w_out_hs     = r_out_valid && out_ready;

    // Single output register: in LAST a new word may enter only when the
    // register is empty or being drained this cycle.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            c_ST_ACCUM: w_in_ready = 1'b1;
            c_ST_LAST:  w_in_ready = !r_in_done && (!r_out_valid || out_ready);
            default:    w_in_ready = 1'b0;
        endcase
    end

    // Per-lane sum and reduction. Poly 0 bypasses the buffer so stale
    // contents from an earlier or aborted run never leak into a result.
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [W-1:0] w_lane_sum;

        assign w_lane_sum = w_first_poly ? in_data[g*W +: W]
                                         : w_buf_rd[g*W +: W] + in_data[g*W +: W];
        assign w_sum[g*W +: W] = w_lane_sum;

        barrett_reduce #(
            .W (W)
        ) u_barrett (
            .a (w_lane_sum),
            .r (w_red[g*W +: W])
        );
    end

    // Accumulator storage carries no reset; every location is rewritten by
    // poly 0 before it is read back.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && (r_state == c_ST_ACCUM)) begin
            r_buf[r_beat] <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_beat      <= '0;
            r_poly      <= '0;
            r_in_done   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_beat    <= '0;
                        r_poly    <= '0;
                        r_in_done <= 1'b0;
                        r_state   <= (K == 1) ? c_ST_LAST : c_ST_ACCUM;
                    end
                end

                c_ST_ACCUM: begin
                    if (w_accept) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_beat_last) begin
                            r_poly <= r_poly + 1'b1;
                            if (r_poly == c_POLY_ACC_END) begin
                                r_state <= c_ST_LAST;
                            end
                        end
                    end
                end

                c_ST_LAST: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_red;
                        r_out_idx   <= r_beat;
                        r_out_last  <= w_beat_last;
                        r_beat      <= r_beat + 1'b1;
                        if (w_beat_last) begin
                            r_in_done <= 1'b1;
                        end
                    end
                    if (w_out_hs && r_out_last) begin
                        r_out_last <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;

endmodule : polyvec_basemul_acc
`default_nettype wire

// File: tb/tb_polyvec_basemul_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_polyvec_basemul_acc
//  Description : Scoreboard bench for polyvec_basemul_acc. A K=3 instance
//                receives directed streams with hand-computed results; a
//                K=1 instance checks the single-poly path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_polyvec_basemul_acc;

    localparam int c_K     = 3;
    localparam int c_BEATS = 128;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [6:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        start_1 = 1'b0;
    logic        in_valid_1 = 1'b0;
    logic        in_ready_1;
    logic [31:0] in_data_1 = '0;
    logic        out_valid_1;
    logic        out_ready_1 = 1'b1;
    logic [31:0] out_data_1;
    logic [6:0]  out_idx_1;
    logic        out_last_1;
    logic        busy_1;
    logic        done_1;

    polyvec_basemul_acc #(.K(c_K), .N(256), .W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    polyvec_basemul_acc #(.K(1), .N(256), .W(16)) u_dut_k1 (
        .clk(clk), .rst(rst), .start(start_1),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1),
        .out_idx(out_idx_1), .out_last(out_last_1), .busy(busy_1), .done(done_1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          n_hs = 0;
    int          n_done = 0;
    int          k1_cnt = 0;
    int          k1_done = 0;
    bit          bp_mode = 1'b0;
    bit          last_phase = 1'b0;
    bit          hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic [6:0]  hold_idx;
    logic        hold_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Input word for test t, poly p, word b.
    function automatic logic [31:0] gen_word(input int t, input int p, input int b);
        case (t)
            0: return 32'h0001_0001;                          // all ones
            1: return 32'h0D00_0D00;                          // 3328
            2: return 32'hF300_F300;                          // -3328
            3: return (p == 0) ? 32'h0681_0681 : 32'h0;       // 1665 then zeros
            4: begin
                if (b != 5) return 32'h0;
                case (p)
                    0:       return 32'h0007_FFFE;            // {7, -2}
                    1:       return 32'h0001_0001;            // {1, 1}
                    default: return 32'h0000_0004;            // {0, 4}
                endcase
            end
            default: return 32'h0064_0064;                    // 100, aborted run
        endcase
    endfunction

    // Hand-computed reduced output word for test t, word b.
    function automatic logic [31:0] exp_word(input int t, input int b);
        case (t)
            0:       return 32'h0003_0003;
            1:       return 32'hFFFD_FFFD;
            2:       return 32'h0003_0003;
            3:       return 32'hF980_F980;
            4:       return (b == 5) ? 32'h0008_0003 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // Output monitor for the K=3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done) n_done++;
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_data", out_data, hold_data);
                check("stall_idx", {25'b0, out_idx}, {25'b0, hold_idx});
                check("stall_last", {31'b0, out_last}, {31'b0, hold_last});
            end
            if (last_phase) begin
                check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got idx %0d data 0x%08h, required no output", out_idx, out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", {25'b0, out_idx}, {25'b0, e.idx});
                    check("out_last", {31'b0, out_last}, {31'b0, e.last});
                end
                hold_valid = 1'b0;
            end else begin
                hold_valid = out_valid;
                hold_data  = out_data;
                hold_idx   = out_idx;
                hold_last  = out_last;
            end
        end
    end

    // Output monitor for the K=1 instance: 3329 per lane reduces to 0.
    always @(negedge clk) begin
        if (done_1) k1_done++;
        if (!rst && out_valid_1 && out_ready_1) begin
            check("k1_data", out_data_1, 32'h0);
            check("k1_idx", {25'b0, out_idx_1}, 32'(k1_cnt % c_BEATS));
            check("k1_last", {31'b0, out_last_1}, {31'b0, (k1_cnt == c_BEATS - 1)});
            k1_cnt++;
        end
    end

    // Run test t. abort_at / start_at are flat word positions (p*128+b), -1 = none.
    task automatic run(input int t, input int abort_at, input int start_at);
        int hs0;
        int done0;
        int guard;
        hs0   = n_hs;
        done0 = n_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        for (int w = 0; w < c_K * c_BEATS; w++) begin
            int p;
            int b;
            p = w / c_BEATS;
            b = w % c_BEATS;
            if (w == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_in_ready", {31'b0, in_ready}, 32'd0);
                check("rst_out_valid", {31'b0, out_valid}, 32'd0);
                rst = 1'b0;
                last_phase = 1'b0;
                return;
            end
            if (w == start_at) start = 1'b1;
            in_valid   = 1'b1;
            in_data    = gen_word(t, p, b);
            last_phase = (p == c_K - 1);
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 1000) begin
                guard++;
                @(negedge clk);
            end
            if (!in_ready) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: test %0d word %0d got in_ready 0, required 1", t, w);
                in_valid = 1'b0;
                last_phase = 1'b0;
                return;
            end
            if (p == c_K - 1) sb.push_back('{exp_word(t, b), 7'(b), (b == c_BEATS - 1)});
            @(posedge clk); #1;
            if (w == start_at) begin
                start = 1'b0;
                check("busy_after_restart", {31'b0, busy}, 32'd1);
            end
        end
        in_valid   = 1'b0;
        last_phase = 1'b0;
        guard = 0;
        while (n_done == done0 && guard < 2000) begin
            guard++;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(n_done - done0), 32'd1);
        check("handshakes", 32'(n_hs - hs0), 32'd128);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        sb.delete();
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_idx", {25'b0, out_idx}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        // in_valid while idle must not be accepted.
        in_valid = 1'b1;
        in_data  = 32'h0001_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_in_ready", {31'b0, in_ready}, 32'd0);
            check("idle_out_valid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        run(0, -1, -1);
        run(1, -1, -1);
        run(2, -1, -1);
        run(3, -1, -1);
        run(4, -1, -1);
        bp_mode = 1'b1;
        run(0, -1, -1);
        bp_mode = 1'b0;
        run(5, c_BEATS + 40, -1);
        run(0, -1, -1);
        run(0, -1, c_BEATS + 10);

        // K=1 instance: ACCUM is skipped, poly 0 is reduced directly.
        start_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0;
        for (int b = 0; b < c_BEATS; b++) begin
            in_valid_1 = 1'b1;
            in_data_1  = 32'h0D01_0D01;
            guard = 0;
            @(negedge clk);
            while (!in_ready_1 && guard < 1000) begin
                guard++;
                @(negedge clk);
            end
            if (!in_ready_1) begin
                tests++;
                fails++;
                $display("FAIL k1_accept_timeout: word %0d got in_ready 0, required 1", b);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid_1 = 1'b0;
        guard = 0;
        while (k1_done == 0 && guard < 1000) begin
            guard++;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("k1_handshakes", 32'(k1_cnt), 32'd128);
        check("k1_done_count", 32'(k1_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_polyvec_basemul_acc
`default_nettype wire
